uart_rx_os: RTL

- Standalone oversampling UART receiver, the receive end for the transmit frames the team's UART driver emits: 1 start bit, 8 data bits LSB first, optional even parity, stop bits.
- Adds input synchronisation, 16x oversampling with majority vote, per-frame error reporting and a valid/ready output holding register.
- Sits between the RX pad and the host-side byte consumer.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_tick.sv | 33 +++
 rtl/uart_rx_os.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver.
// Holds the receiver state encoding and the tick divider arithmetic.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

  function automatic int tick_div(input int clk_hz, input int baud, input int os);
    return clk_hz / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator.
// Emits a one-cycle tick every TICK_DIV clocks.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD_RATE   = 115200,
  parameter int OVERSAMPLE  = 16
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DIV = tick_div(CLK_FREQ_HZ, BAUD_RATE, OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: synchroniser, 2-of-3 vote, frame FSM
// and a valid/ready holding register with error flags.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD_RATE   = 115200,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       parity_en,
  input  logic       rx_ready,
  output logic [8:0] data_out,
  output logic       rx_valid,
  output logic       framing_err,
  output logic       parity_err,
  output logic       overrun_err,
  output logic       rx_busy
);

  localparam logic [3:0] T_A   = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] T_B   = 4'(OVERSAMPLE / 2);
  localparam logic [3:0] T_C   = 4'(OVERSAMPLE / 2 + 1);
  localparam logic [3:0] T_END = 4'(OVERSAMPLE - 1);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic tick;

  uart_baud_tick #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .BAUD_RATE  (BAUD_RATE),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  logic [SYNC_STAGES-1:0] sync_q;
  logic rx_s;
  logic rx_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= (sync_q << 1) | SYNC_STAGES'(RX);
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  rx_state_t  state;
  logic [3:0] tcnt;
  logic [2:0] samp;
  logic [2:0] bitcnt;
  logic [7:0] shreg;
  logic       par_q;
  logic       perr_q;
  logic       ferr_q;
  logic       done;
  logic       bit_end;
  logic       mid;
  logic       vote_end;
  logic       vote_mid;

  assign bit_end  = tick && (tcnt == T_END);
  assign mid      = tick && (tcnt == T_C);
  assign vote_end = maj3(samp[0], samp[1], samp[2]);
  // The third stop sample is still on the line when the mid-bit vote forms.
  assign vote_mid = maj3(samp[0], samp[1], rx_s);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tcnt    <= '0;
      samp    <= '0;
      bitcnt  <= '0;
      shreg   <= '0;
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      done    <= 1'b0;
      rx_prev <= 1'b1;
    end else begin
      done    <= 1'b0;
      rx_prev <= rx_s;
      if (tick) begin
        tcnt <= (tcnt == T_END) ? 4'd0 : tcnt + 4'd1;
        if (tcnt == T_A) samp[0] <= rx_s;
        if (tcnt == T_B) samp[1] <= rx_s;
        if (tcnt == T_C) samp[2] <= rx_s;
      end
      case (state)
        IDLE: begin
          if (rx_prev && !rx_s) begin
            state <= START;
            tcnt  <= '0;
          end
        end
        START: begin
          if (bit_end) begin
            if (vote_end) begin
              state <= IDLE;
            end else begin
              state  <= DATA;
              bitcnt <= '0;
              par_q  <= parity_en;
              perr_q <= 1'b0;
            end
          end
        end
        DATA: begin
          if (bit_end) begin
            shreg  <= {vote_end, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) state <= par_q ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (bit_end) begin
            perr_q <= (vote_end != even_parity(shreg));
            state  <= STOP;
          end
        end
        STOP: begin
          if (mid) begin
            done   <= 1'b1;
            ferr_q <= ~vote_mid;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rx_busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out    <= '0;
      rx_valid    <= 1'b0;
      framing_err <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (done) begin
        if (!rx_valid || rx_ready) begin
          data_out    <= {par_q, shreg};
          framing_err <= ferr_q;
          parity_err  <= perr_q;
          rx_valid    <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid    <= 1'b0;
        framing_err <= 1'b0;
        parity_err  <= 1'b0;
      end
    end
  end

endmodule
